// File: rtl/uart_pkg.sv
// Shared types and helpers for the 16550 receive path.
package uart_pkg;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam int LSR_DR       = 0;
  localparam int LSR_OE       = 1;
  localparam int LSR_PE       = 2;
  localparam int LSR_FE       = 3;
  localparam int LSR_BI       = 4;
  localparam int LSR_FIFO_ERR = 7;

  // FCR[7:6] receive trigger level in entries.
  function automatic logic [3:0] trig_decode(input logic [1:0] lvl);
    logic [3:0] n;
    case (lvl)
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd4;
      2'b10:   n = 4'd8;
      default: n = 4'd14;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: first-word-fall-through storage of {bi, fe, pe, data} with
// occupancy and a running count of errored entries.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_en,
  input  logic          clr,
  input  logic          push,
  input  logic [10:0]   din,
  input  logic          pop,
  output logic [10:0]   head,
  output logic [CW-1:0] count,
  output logic          err_nz,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t         mem_q [DEPTH];
  rx_entry_t         din_s;
  rx_entry_t         rd_entry_s;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d, err_q, err_d, eff_depth_s;
  logic              pop_ok_s, push_ok_s, wr_en_s, push_err_s, pop_err_s;

  // Next-state pointer, occupancy and error-count logic.
  always_comb begin
    din_s       = rx_entry_t'(din);
    rd_entry_s  = mem_q[rd_ptr_q];
    eff_depth_s = fifo_en ? CW'(DEPTH) : CW'(1);
    pop_ok_s    = pop && (count_q != '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push_ok_s   = push && ((count_q < eff_depth_s) || pop_ok_s);
    push_err_s  = push_ok_s && (din_s.bi || din_s.fe || din_s.pe);
    pop_err_s   = pop_ok_s && (rd_entry_s.bi || rd_entry_s.fe || rd_entry_s.pe);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    wr_en_s     = 1'b0;
    overrun     = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      overrun  = push && !push_ok_s;
      wr_en_s  = push_ok_s;
      wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
      err_d    = err_q + CW'(push_err_s) - CW'(pop_err_s);
    end
    head   = (count_q != '0) ? rd_entry_s : '0;
    count  = count_q;
    err_nz = (err_q != '0);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= din_s;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud generator, receive FIFO wrapper, line status,
// character timeout and receive interrupts.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             fifo_en,
  input  logic             fifo_clr,
  input  logic [1:0]       trig_lvl,
  input  logic [1:0]       wls,
  input  logic             pen,
  input  logic             stb,
  input  logic             rx_push,
  input  logic [7:0]       rx_data,
  input  logic             rx_pe,
  input  logic             rx_fe,
  input  logic             rx_bi,
  input  logic             rd_en,
  input  logic             lsr_rd,
  output logic             baud_pulse,
  output logic [7:0]       rd_data,
  output logic             dr,
  output logic             oe,
  output logic             pe,
  output logic             fe,
  output logic             bi,
  output logic             fifo_err,
  output logic             rda_int,
  output logic             cti_int,
  output logic             rls_int
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             baud_pulse_q, baud_pulse_d;
  logic             fifo_en_q;
  logic             oe_q, oe_d;
  logic [9:0]       tmo_q, tmo_d, tmo_lim_s;
  logic [3:0]       char_bits_s;
  logic             clr_s, overrun_s, err_nz_s;
  logic [10:0]      head_bits_s;
  rx_entry_t        head_s;
  logic [CW-1:0]    count_s;

  assign clr_s = fifo_clr || (fifo_en != fifo_en_q);

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .fifo_en(fifo_en),
    .clr    (clr_s),
    .push   (rx_push),
    .din    ({rx_bi, rx_fe, rx_pe, rx_data}),
    .pop    (rd_en),
    .head   (head_bits_s),
    .count  (count_s),
    .err_nz (err_nz_s),
    .overrun(overrun_s)
  );

  // Baud down-counter, sticky overrun and character-timeout next state.
  always_comb begin
    if (divisor == '0) begin
      baud_cnt_d = '0;
    end else if (baud_cnt_q == '0) begin
      baud_cnt_d = divisor - DIV_W'(1);
    end else begin
      baud_cnt_d = baud_cnt_q - DIV_W'(1);
    end
    // Registered so the pulse lines up with the counter sitting at zero.
    baud_pulse_d = (divisor != '0) && (baud_cnt_d == '0);

    if (overrun_s) begin
      oe_d = 1'b1;
    end else if (lsr_rd) begin
      oe_d = 1'b0;
    end else begin
      oe_d = oe_q;
    end

    // Four character times = 64 baud ticks per bit of the frame.
    char_bits_s = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
    tmo_lim_s   = {char_bits_s, 6'b000000};
    if (clr_s || rx_push || rd_en || (count_s == '0)) begin
      tmo_d = '0;
    end else if (baud_pulse_q && (tmo_q < tmo_lim_s)) begin
      tmo_d = tmo_q + 10'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Status and interrupt outputs, all derived from register state.
  always_comb begin
    head_s     = rx_entry_t'(head_bits_s);
    baud_pulse = baud_pulse_q;
    dr         = (count_s != '0);
    rd_data    = head_s.data;
    pe         = head_s.pe;
    fe         = head_s.fe;
    bi         = head_s.bi;
    oe         = oe_q;
    fifo_err   = fifo_en && err_nz_s;
    rda_int    = fifo_en ? (count_s >= CW'(trig_decode(trig_lvl))) : dr;
    cti_int    = fifo_en && dr && (tmo_q >= tmo_lim_s);
    rls_int    = oe_q || (dr && (head_s.pe || head_s.fe || head_s.bi));
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_q   <= '0;
      baud_pulse_q <= 1'b0;
      fifo_en_q    <= 1'b0;
      oe_q         <= 1'b0;
      tmo_q        <= '0;
    end else begin
      baud_cnt_q   <= baud_cnt_d;
      baud_pulse_q <= baud_pulse_d;
      fifo_en_q    <= fifo_en;
      oe_q         <= oe_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue-based reference model.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic        fifo_en, fifo_clr, pen, stb, rx_push, rx_pe, rx_fe, rx_bi, rd_en, lsr_rd;
  logic [1:0]  trig_lvl, wls;
  logic [7:0]  rx_data;
  logic        baud_pulse, dr, oe, pe, fe, bi, fifo_err, rda_int, cti_int, rls_int;
  logic [7:0]  rd_data;
  logic [15:0] obs_s;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] mq[$];
  logic        m_oe;
  logic        m_fen;
  int          trig_tab[4] = '{1, 4, 8, 14};

  always #5 clk = ~clk;

  assign obs_s = {rd_data, dr, oe, pe, fe, bi, fifo_err, rda_int, rls_int};

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .divisor(divisor), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
    .trig_lvl(trig_lvl), .wls(wls), .pen(pen), .stb(stb), .rx_push(rx_push),
    .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi), .rd_en(rd_en),
    .lsr_rd(lsr_rd), .baud_pulse(baud_pulse), .rd_data(rd_data), .dr(dr), .oe(oe),
    .pe(pe), .fe(fe), .bi(bi), .fifo_err(fifo_err), .rda_int(rda_int),
    .cti_int(cti_int), .rls_int(rls_int)
  );

  // Expected {rd_data, dr, oe, pe, fe, bi, fifo_err, rda_int, rls_int} from the model.
  function automatic logic [15:0] exp_vec();
    logic [10:0] h;
    logic        dr_e, rda_e, rls_e;
    int          nerr;
    h    = (mq.size() != 0) ? mq[0] : 11'd0;
    dr_e = (mq.size() != 0);
    nerr = 0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) nerr++;
    rda_e = fifo_en ? (mq.size() >= trig_tab[trig_lvl]) : dr_e;
    rls_e = m_oe | (dr_e & (h[10:8] != 3'b000));
    return {h[7:0], dr_e, m_oe, h[8], h[9], h[10], fifo_en && (nerr != 0), rda_e, rls_e};
  endfunction

  function automatic logic [10:0] rand_ent();
    logic [2:0] e;
    e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    return {e, 8'($urandom)};
  endfunction

  // One clock of stimulus; the model applies the receive-FIFO rules at the edge.
  task automatic step(input logic push, input logic [10:0] ent, input logic rd,
                      input logic lsr, input logic clr);
    logic ovr, pop_ok, full;
    @(negedge clk);
    rx_push = push; {rx_bi, rx_fe, rx_pe, rx_data} = ent;
    rd_en = rd; lsr_rd = lsr; fifo_clr = clr;
    @(posedge clk);
    ovr = 1'b0;
    if (clr || (fifo_en != m_fen)) begin
      mq.delete();
    end else begin
      pop_ok = rd && (mq.size() != 0);
      full   = (mq.size() == (fifo_en ? 16 : 1));
      if (pop_ok) void'(mq.pop_front());
      if (push) begin
        if (full && !pop_ok) ovr = 1'b1;
        else mq.push_back(ent);
      end
    end
    m_fen = fifo_en;
    if (ovr) m_oe = 1'b1;
    else if (lsr) m_oe = 1'b0;
    #1;
    rx_push = 1'b0; rd_en = 1'b0; lsr_rd = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!baud_pulse && n < 50);
    if (!baud_pulse) n = -1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; divisor = 16'd6; fifo_en = 1'b0; fifo_clr = 1'b0; trig_lvl = 2'b00;
    wls = 2'b00; pen = 1'b0; stb = 1'b0; rx_push = 1'b0; rx_data = 8'd0;
    rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0; rd_en = 1'b0; lsr_rd = 1'b0;
    mq.delete(); m_oe = 1'b0; m_fen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({obs_s, baud_pulse, cti_int} !== 18'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {obs_s, baud_pulse, cti_int});
    end
    @(negedge clk); rst = 1'b1;
    wait_pulse(n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL first_pulse: got %0d clocks expected 6", n); end
  endtask

  task automatic test_baud();
    int n, hi;
    wait_pulse(n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL period_6: got %0d expected 6", n); end
    repeat (2) @(posedge clk);
    #1; divisor = 16'd3;
    // Two clocks of the running 6-clock period already elapsed.
    wait_pulse(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL div_change_tail: got %0d expected 4", n); end
    for (int k = 0; k < 2; k++) begin
      wait_pulse(n);
      checks++;
      if (n != 3) begin errors++; $display("FAIL period_3: got %0d expected 3", n); end
    end
    divisor = 16'd0; hi = 0;
    repeat (30) begin @(posedge clk); #1; hi += int'(baud_pulse); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL div0_pulses: got %0d expected 0", hi); end
    divisor = 16'd1; hi = 0;
    repeat (8) begin @(posedge clk); #1; hi += int'(baud_pulse); end
    checks++;
    if (hi != 8) begin errors++; $display("FAIL div1_pulses: got %0d expected 8", hi); end
    divisor = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [15:0] e;
    fifo_en = 1'b1; trig_lvl = 2'b00;
    step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, {3'b000, 8'h45}, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({dr, rd_data, rda_int} !== {1'b1, 8'h45, 1'b1}) begin
      errors++; $display("FAIL first_push: got %h expected %h", {dr, rd_data, rda_int}, {1'b1, 8'h45, 1'b1});
    end
    step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, {3'b000, 8'(i)}, 1'b0, 1'b0, 1'b0);
    step(1'b1, {3'b000, 8'hAA}, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({oe, rls_int, rd_data} !== {1'b1, 1'b1, 8'h00}) begin
      errors++; $display("FAIL overrun_set: got %h expected %h", {oe, rls_int, rd_data}, {1'b1, 1'b1, 8'h00});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin errors++; $display("FAIL drain_order: got %h expected %h", rd_data, 8'(i)); end
      step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (dr !== 1'b0) begin errors++; $display("FAIL drained_dr: got %b expected 0", dr); end
    step(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL oe_clear: got %b expected 0", oe); end
    for (int i = 0; i < 16; i++) step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_ent(), 1'b1, 1'b0, 1'b0);
    e = exp_vec();
    checks++;
    if (obs_s !== e || oe !== 1'b0) begin
      errors++; $display("FAIL full_push_pop: got %h expected %h", obs_s, e);
    end
    step(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, {3'b000, 8'h77}, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({dr, rd_data} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL pop_empty: got %h expected %h", {dr, rd_data}, {1'b1, 8'h77});
    end
  endtask

  task automatic test_trigger();
    logic [15:0] e;
    int n;
    trig_lvl = 2'b10;
    step(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    checks++;
    if (rda_int !== 1'b0) begin errors++; $display("FAIL trig8_below: got %b expected 0", rda_int); end
    step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    checks++;
    if (rda_int !== 1'b1) begin errors++; $display("FAIL trig8_reach: got %b expected 1", rda_int); end
    step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (rda_int !== 1'b0) begin errors++; $display("FAIL trig8_read: got %b expected 0", rda_int); end
    for (int r = 0; r < 6; r++) begin
      trig_lvl = 2'($urandom);
      n = $urandom_range(0, 16);
      step(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
      e = exp_vec();
      checks++;
      if (obs_s !== e) begin errors++; $display("FAIL trig_random: got %h expected %h", obs_s, e); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] e;
    step(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, {3'b000, 8'h12}, 1'b0, 1'b0, 1'b0);
    step(1'b1, {3'b010, 8'h34}, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({fifo_err, fe} !== 2'b10) begin errors++; $display("FAIL err_pushed: got %b expected 10", {fifo_err, fe}); end
    step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({fe, rls_int} !== 2'b11) begin errors++; $display("FAIL err_at_head: got %b expected 11", {fe, rls_int}); end
    step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fifo_err !== 1'b0) begin errors++; $display("FAIL err_popped: got %b expected 0", fifo_err); end
    for (int i = 0; i < 10; i++) step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      e = exp_vec();
      checks++;
      if (obs_s !== e) begin errors++; $display("FAIL err_random: got %h expected %h", obs_s, e); end
      step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout();
    int thresh;
    for (int k = 0; k < 3; k++) begin
      divisor = 16'd0;
      step(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
      if (k == 0) begin wls = 2'b11; pen = 1'b1; stb = 1'b0; end
      else begin wls = 2'($urandom); pen = 1'($urandom); stb = 1'($urandom); end
      thresh = 64 * (1 + 5 + int'(wls) + int'(pen) + (stb ? 2 : 1));
      divisor = 16'd1;
      step(1'b1, {3'b000, 8'h5A}, 1'b0, 1'b0, 1'b0);
      step(1'b1, {3'b000, 8'hA5}, 1'b0, 1'b0, 1'b0);
      repeat (thresh - 1) @(posedge clk);
      #1;
      checks++;
      if (cti_int !== 1'b0) begin errors++; $display("FAIL cti_early: got %b expected 0 (thresh %0d)", cti_int, thresh); end
      @(posedge clk); #1;
      checks++;
      if (cti_int !== 1'b1) begin errors++; $display("FAIL cti_rise: got %b expected 1 (thresh %0d)", cti_int, thresh); end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (cti_int !== 1'b1) begin errors++; $display("FAIL cti_hold: got %b expected 1", cti_int); end
      step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({cti_int, dr} !== 2'b01) begin errors++; $display("FAIL cti_read: got %b expected 01", {cti_int, dr}); end
      divisor = 16'd0;
      step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_16450();
    fifo_en = 1'b0;
    step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, {3'b000, 8'hC1}, 1'b0, 1'b0, 1'b0);
    step(1'b1, {3'b000, 8'hC2}, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({oe, rd_data, rda_int} !== {1'b1, 8'hC1, 1'b1}) begin
      errors++; $display("FAIL mode16450_ovr: got %h expected %h", {oe, rd_data, rda_int}, {1'b1, 8'hC1, 1'b1});
    end
    step(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL mode16450_lsr: got %b expected 0", oe); end
    step(1'b1, {3'b000, 8'hC3}, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dr !== 1'b0) begin errors++; $display("FAIL clr_vs_push: got %b expected 0", dr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic        p, r;
    for (int m = 0; m < 2; m++) begin
      fifo_en = (m == 0);
      step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 240; i++) begin
        if (i % 40 == 0) trig_lvl = 2'($urandom);
        p = ($urandom_range(0, 99) < ((i < 120) ? 75 : 35));
        r = ($urandom_range(0, 99) < ((i < 120) ? 30 : 70));
        step(p, rand_ent(), r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        e = exp_vec();
        checks++;
        if (obs_s !== e) begin errors++; $display("FAIL random_mix: cycle %0d got %h expected %h", i, obs_s, e); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    int n;
    fifo_en = 1'b0;
    step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_ent(), 1'b0, 1'b0, 1'b0);
    divisor = 16'd5;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({obs_s, baud_pulse, cti_int} !== 18'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {obs_s, baud_pulse, cti_int});
    end
    mq.delete(); m_oe = 1'b0; m_fen = fifo_en;
    @(negedge clk); rst = 1'b1;
    wait_pulse(n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL restart_pulse: got %0d expected 5", n); end
    divisor = 16'd0;
    step(1'b1, {3'b001, 8'h3C}, 1'b0, 1'b0, 1'b0);
    e = exp_vec();
    checks++;
    if (obs_s !== e) begin errors++; $display("FAIL after_reset: got %h expected %h", obs_s, e); end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_overrun();
    test_trigger();
    test_errors();
    test_timeout();
    test_16450();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
